// File: rtl/slv_fsm_mc.sv
// rtl/slv_fsm_mc.sv - multi-channel slave access state machine
//
// Terminates one upstream register-interface request per transaction and
// serves it as a dummy (unmapped) access, a local register access, or by
// forwarding it to one of EXT_NUM external channels.
//
// Optional feature: define SLV_FSM_MC_TIMEOUT_EN to build the external-wait
// timeout (counter, TMO_ACK state, tmo_evt). Without it EXT_WAIT waits
// indefinitely and tmo_evt is tied low.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   if_soft_rst        synchronous soft reset, same effect as rst
//   if_req_vld         upstream request strobe
//   if_wr_en/if_rd_en  request direction (write wins)
//   if_err_en          report errors on dummy accesses
//   if_ack_vld         one-cycle response strobe (registered)
//   if_rd_data         response data, 0 outside if_ack_vld (registered)
//   if_err             response error (registered)
//   dummy_acc          address hits nothing
//   reg_acc            local register write accepted
//   reg_rd_data(_vld)  local register read data / valid
//   ext_sel            one-hot external channel decode
//   ext_req_vld        one-hot one-cycle forward strobe (registered)
//   ext_ack_vld        per-channel completion
//   ext_rd_data        per-channel read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ext_err            per-channel error, qualified by ext_ack_vld
//   busy               high whenever not IDLE (registered)
//   tmo_evt            one-cycle pulse on timeout abort (registered)

module slv_fsm_mc #(
    parameter int DATA_WIDTH     = 32,
    parameter int EXT_NUM        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          if_soft_rst,
    input  logic                          if_req_vld,
    input  logic                          if_wr_en,
    input  logic                          if_rd_en,
    input  logic                          if_err_en,
    output logic                          if_ack_vld,
    output logic [DATA_WIDTH-1:0]         if_rd_data,
    output logic                          if_err,
    input  logic                          dummy_acc,
    input  logic                          reg_acc,
    input  logic [DATA_WIDTH-1:0]         reg_rd_data,
    input  logic                          reg_rd_data_vld,
    input  logic [EXT_NUM-1:0]            ext_sel,
    output logic [EXT_NUM-1:0]            ext_req_vld,
    input  logic [EXT_NUM-1:0]            ext_ack_vld,
    input  logic [EXT_NUM*DATA_WIDTH-1:0] ext_rd_data,
    input  logic [EXT_NUM-1:0]            ext_err,
    output logic                          busy,
    output logic                          tmo_evt
);

    localparam int IDX_W = (EXT_NUM > 1) ? $clog2(EXT_NUM) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DUMMY_ACK,
        REG_ACK,
        EXT_REQ,
        EXT_WAIT,
        EXT_ACK
`ifdef SLV_FSM_MC_TIMEOUT_EN
        ,TMO_ACK
`endif
    } state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx_q, idx_nxt;
    logic                    wr_q, wr_nxt;
    logic                    ack_nxt;
    logic                    err_nxt;
    logic                    tmo_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic [EXT_NUM-1:0]      req_nxt;

`ifdef SLV_FSM_MC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_nxt;
`endif

    // Lowest set bit wins when the decode is not strictly one-hot.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [EXT_NUM-1:0] v);
        lowest_set = '0;
        for (int i = EXT_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        wr_nxt    = wr_q;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        data_nxt  = '0;
        req_nxt   = '0;
`ifdef SLV_FSM_MC_TIMEOUT_EN
        cnt_nxt   = cnt_q;
`endif
        case (state)
            IDLE: begin
                if (if_req_vld && (if_wr_en || if_rd_en)) begin
                    if (dummy_acc) begin
                        state_nxt = DUMMY_ACK;
                        ack_nxt   = 1'b1;
                        err_nxt   = if_err_en;
                    end else if ((if_wr_en && reg_acc) || (!if_wr_en && reg_rd_data_vld)) begin
                        state_nxt = REG_ACK;
                        ack_nxt   = 1'b1;
                        data_nxt  = if_wr_en ? '0 : reg_rd_data;
                    end else if (|ext_sel) begin
                        state_nxt = EXT_REQ;
                        idx_nxt   = lowest_set(ext_sel);
                        wr_nxt    = if_wr_en;
                        for (int i = 0; i < EXT_NUM; i++) begin
                            req_nxt[i] = (idx_nxt == IDX_W'(i));
                        end
                    end else begin
                        // Decode miss: nothing claimed the address.
                        state_nxt = DUMMY_ACK;
                        ack_nxt   = 1'b1;
                        err_nxt   = if_err_en;
                    end
                end
            end
            EXT_REQ: begin
                state_nxt = EXT_WAIT;
`ifdef SLV_FSM_MC_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
            end
            EXT_WAIT: begin
                // An ack in the last wait cycle takes precedence over the timeout.
                if (ext_ack_vld[idx_q]) begin
                    state_nxt = EXT_ACK;
                    ack_nxt   = 1'b1;
                    err_nxt   = ext_err[idx_q];
                    data_nxt  = wr_q ? '0 : ext_rd_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
                end
`ifdef SLV_FSM_MC_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = TMO_ACK;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    tmo_nxt   = 1'b1;
                end else begin
                    cnt_nxt   = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                // Every *_ACK state presents its response for one cycle only.
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with
    // the state they belong to.
    always_ff @(posedge clk) begin
        if (rst || if_soft_rst) begin
            state       <= IDLE;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            if_ack_vld  <= 1'b0;
            if_rd_data  <= '0;
            if_err      <= 1'b0;
            ext_req_vld <= '0;
            busy        <= 1'b0;
            tmo_evt     <= 1'b0;
`ifdef SLV_FSM_MC_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state       <= state_nxt;
            idx_q       <= idx_nxt;
            wr_q        <= wr_nxt;
            if_ack_vld  <= ack_nxt;
            if_rd_data  <= data_nxt;
            if_err      <= err_nxt;
            ext_req_vld <= req_nxt;
            busy        <= (state_nxt != IDLE);
            tmo_evt     <= tmo_nxt;
`ifdef SLV_FSM_MC_TIMEOUT_EN
            cnt_q       <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_slv_fsm_mc.sv
// tb/tb_slv_fsm_mc.sv - randomized and directed bench for slv_fsm_mc

module tb_slv_fsm_mc;

    localparam int DW = 32;
    localparam int EN = 4;
    localparam int TC = 8;

    logic           clk = 1'b0;
    logic           rst, if_soft_rst, if_req_vld, if_wr_en, if_rd_en, if_err_en;
    logic           if_ack_vld, if_err, busy, tmo_evt;
    logic [DW-1:0]  if_rd_data;
    logic           dummy_acc, reg_acc, reg_rd_data_vld;
    logic [DW-1:0]  reg_rd_data;
    logic [EN-1:0]  ext_sel, ext_req_vld, ext_ack_vld, ext_err;
    logic [EN*DW-1:0] ext_rd_data;

    int n_vec  = 0;
    int n_fail = 0;

    slv_fsm_mc #(.DATA_WIDTH(DW), .EXT_NUM(EN), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .if_soft_rst(if_soft_rst),
        .if_req_vld(if_req_vld), .if_wr_en(if_wr_en), .if_rd_en(if_rd_en),
        .if_err_en(if_err_en), .if_ack_vld(if_ack_vld), .if_rd_data(if_rd_data),
        .if_err(if_err), .dummy_acc(dummy_acc), .reg_acc(reg_acc),
        .reg_rd_data(reg_rd_data), .reg_rd_data_vld(reg_rd_data_vld),
        .ext_sel(ext_sel), .ext_req_vld(ext_req_vld), .ext_ack_vld(ext_ack_vld),
        .ext_rd_data(ext_rd_data), .ext_err(ext_err), .busy(busy), .tmo_evt(tmo_evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: transaction timeline by cycle number
    logic           e_ack = 0, e_err = 0, e_busy = 0, e_tmo = 0;
    logic [DW-1:0]  e_data = '0;
    logic [EN-1:0]  e_req = '0;
    bit             have = 0;
    bit             m_wr;
    int             m_ch;
    int             t_acc;
    int             end_cyc;
    int             cyc = 0;
    bit             tmo_built;

    initial begin
`ifdef SLV_FSM_MC_TIMEOUT_EN
        tmo_built = 1'b1;
`else
        tmo_built = 1'b0;
`endif
    end

    always @(negedge clk) begin
        check("ack",  if_ack_vld,  e_ack);
        check("data", if_rd_data,  e_data);
        check("err",  if_err,      e_err);
        check("req",  ext_req_vld, e_req);
        check("busy", busy,        e_busy);
        check("tmo",  tmo_evt,     e_tmo);

        e_ack = 0; e_err = 0; e_tmo = 0; e_data = '0; e_req = '0;
        if (rst || if_soft_rst) begin
            have   = 0;
            e_busy = 0;
        end else if (!have || (end_cyc >= 0 && cyc > end_cyc)) begin
            have   = 0;
            e_busy = 0;
            if (if_req_vld && (if_wr_en || if_rd_en)) begin
                have   = 1;
                t_acc  = cyc;
                e_busy = 1;
                if (dummy_acc) begin
                    end_cyc = cyc + 1; e_ack = 1; e_err = if_err_en;
                end else if ((if_wr_en && reg_acc) || (!if_wr_en && reg_rd_data_vld)) begin
                    end_cyc = cyc + 1; e_ack = 1; e_data = if_wr_en ? '0 : reg_rd_data;
                end else if (ext_sel != 0) begin
                    m_ch = 0;
                    while (!ext_sel[m_ch]) m_ch++;
                    m_wr    = if_wr_en;
                    end_cyc = -1;
                    e_req   = EN'(1) << m_ch;
                end else begin
                    end_cyc = cyc + 1; e_ack = 1; e_err = if_err_en;
                end
            end
        end else begin
            if (end_cyc < 0 && cyc >= t_acc + 2) begin
                if (ext_ack_vld[m_ch]) begin
                    end_cyc = cyc + 1;
                    e_ack   = 1;
                    e_err   = ext_err[m_ch];
                    e_data  = m_wr ? '0 : ext_rd_data[m_ch*DW +: DW];
                end else if (tmo_built && cyc == t_acc + 1 + TC) begin
                    end_cyc = cyc + 1;
                    e_ack = 1; e_err = 1; e_tmo = 1;
                end
            end
            e_busy = (end_cyc < 0) || (cyc + 1 <= end_cyc);
        end
        cyc++;
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        if_soft_rst = 0; if_req_vld = 0; if_wr_en = 0; if_rd_en = 0; if_err_en = 0;
        dummy_acc = 0; reg_acc = 0; reg_rd_data_vld = 0; reg_rd_data = '0;
        ext_sel = '0; ext_ack_vld = '0; ext_err = '0; ext_rd_data = '0;
    endtask

    task automatic start_ext(input logic wr, input logic [EN-1:0] sel);
        tick();
        if_req_vld = 1; if_wr_en = wr; if_rd_en = !wr; ext_sel = sel;
        tick();
        clear_in();
    endtask

    initial begin
        rst = 1;
        clear_in();
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        check("rst_ack",  if_ack_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_req",  ext_req_vld, 0);

        // register read
        tick();
        if_req_vld = 1; if_rd_en = 1; reg_rd_data_vld = 1; reg_rd_data = 32'hA5A5_0001;
        tick();
        clear_in();
        @(negedge clk);
        check("regrd_ack",  if_ack_vld, 1);
        check("regrd_data", if_rd_data, 64'hA5A5_0001);
        check("regrd_req",  ext_req_vld, 0);

        // dummy write, with and without error reporting
        for (int e = 1; e >= 0; e--) begin
            tick();
            if_req_vld = 1; if_wr_en = 1; dummy_acc = 1; if_err_en = e[0];
            tick();
            clear_in();
            @(negedge clk);
            check("dummy_ack", if_ack_vld, 1);
            check("dummy_err", if_err, 64'(e));
        end

        // external read on channel 2, foreign acks ignored
        start_ext(1'b0, 4'b0100);
        @(negedge clk);
        check("ext2_req", ext_req_vld, 4'b0100);
        for (int k = 2; k <= 6; k++) begin
            tick();
            if (k < 6) begin
                ext_ack_vld = 4'b1011;
                ext_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                ext_ack_vld = 4'b0100;
                ext_rd_data[2*DW +: DW] = 32'h1234_5678;
            end
        end
        tick();
        clear_in();
        @(negedge clk);
        check("ext2_ack",  if_ack_vld, 1);
        check("ext2_data", if_rd_data, 64'h1234_5678);
        check("ext2_err",  if_err, 0);

`ifdef SLV_FSM_MC_TIMEOUT_EN
        // timeout with no ack
        start_ext(1'b0, 4'b0001);
        repeat (9) tick();
        @(negedge clk);
        check("tmo_ack", if_ack_vld, 1);
        check("tmo_err", if_err, 1);
        check("tmo_evt", tmo_evt, 1);
        // ack in the final wait cycle beats the timeout
        start_ext(1'b0, 4'b0001);
        repeat (8) tick();
        ext_ack_vld = 4'b0001; ext_rd_data[DW-1:0] = 32'hCAFE_0009;
        tick();
        clear_in();
        @(negedge clk);
        check("late_ack",  if_ack_vld, 1);
        check("late_tmo",  tmo_evt, 0);
        check("late_data", if_rd_data, 64'hCAFE_0009);
`endif

        // soft reset during the wait, then a late ack
        start_ext(1'b0, 4'b1000);
        tick();
        if_soft_rst = 1;
        tick();
        if_soft_rst = 0; ext_ack_vld = 4'b1000;
        @(negedge clk);
        check("srst_busy", busy, 0);
        tick();
        clear_in();
        @(negedge clk);
        check("srst_noack", if_ack_vld, 0);
        if_req_vld = 1; if_wr_en = 1; reg_acc = 1;
        tick();
        clear_in();
        @(negedge clk);
        check("srst_reg_ack", if_ack_vld, 1);

        // non-one-hot decode, write with error
        start_ext(1'b1, 4'b0110);
        @(negedge clk);
        check("sel_req", ext_req_vld, 4'b0010);
        tick();
        ext_ack_vld = 4'b0010; ext_err = 4'b0010; ext_rd_data = {4{32'hDEAD_BEEF}};
        tick();
        clear_in();
        @(negedge clk);
        check("wr_err",  if_err, 1);
        check("wr_data", if_rd_data, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst             = ($urandom_range(0, 199) == 0);
            if_soft_rst     = ($urandom_range(0, 49) == 0);
            if_req_vld      = ($urandom_range(0, 2) != 0);
            if_wr_en        = $urandom_range(0, 1);
            if_rd_en        = $urandom_range(0, 1);
            if_err_en       = $urandom_range(0, 1);
            dummy_acc       = ($urandom_range(0, 5) == 0);
            reg_acc         = ($urandom_range(0, 2) == 0);
            reg_rd_data_vld = ($urandom_range(0, 2) == 0);
            reg_rd_data     = $urandom;
            ext_sel         = EN'($urandom);
            ext_ack_vld     = EN'($urandom & $urandom);
            ext_err         = EN'($urandom);
            ext_rd_data     = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
        rst = 0;
        clear_in();
        repeat (4) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
